// File: rtl/grant_lock.sv
// Ownership stage around a 4-way fixed-priority selector.
// Latches a one-hot grant, enforces a hold limit and a one-arbitration penalty after a timeout.
module grant_lock #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CW       = $clog2(MAX_HOLD)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] gnt_in,
    output logic [3:0] req_masked,
    output logic       en_out,
    output logic [3:0] gnt_out,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic [3:0]    owner_q, owner_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    penalty_q, penalty_d;
    logic          timeout_q, timeout_d;
    logic [3:0]    gnt_top;

    assign req_masked = req & ~penalty_q;
    assign timeout    = timeout_q;

    // A malformed multi-bit grant is reduced to its highest-priority bit.
    always_comb begin
        gnt_top = '0;
        if (gnt_in[3])      gnt_top = 4'b1000;
        else if (gnt_in[2]) gnt_top = 4'b0100;
        else if (gnt_in[1]) gnt_top = 4'b0010;
        else if (gnt_in[0]) gnt_top = 4'b0001;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        count_d   = count_q;
        penalty_d = penalty_q;
        timeout_d = 1'b0;
        en_out    = 1'b0;
        busy      = 1'b0;
        gnt_out   = '0;
        case (state_q)
            IDLE: begin
                en_out = 1'b1;
                if (gnt_in != 4'b0000) begin
                    owner_d   = gnt_top;
                    count_d   = '0;
                    penalty_d = '0;
                    state_d   = OWN;
                end else if (req_masked == 4'b0000 && penalty_q != 4'b0000) begin
                    penalty_d = '0;
                end
            end
            OWN: begin
                busy    = 1'b1;
                gnt_out = owner_q;
                if ((req & owner_q) == 4'b0000) begin
                    state_d = GAP;
                end else if (count_q == LAST) begin
                    penalty_d = penalty_q | owner_q;
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            count_q   <= '0;
            penalty_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            count_q   <= count_d;
            penalty_q <= penalty_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_grant_lock.sv
// Bench for grant_lock: directed vector table, hand sequences and a randomised soak
// against a cycle-level ownership model.
module tb_grant_lock;

    localparam int unsigned MAX_HOLD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt_in;
    logic [3:0] req_masked;
    logic       en_out;
    logic [3:0] gnt_out;
    logic       busy;
    logic       timeout;

    logic       frc;
    logic [3:0] fgnt;

    int tests = 0;
    int fails = 0;

    grant_lock #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .gnt_in     (gnt_in),
        .req_masked (req_masked),
        .en_out     (en_out),
        .gnt_out    (gnt_out),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    function automatic int hi_idx(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] bit_of(input int idx);
        logic [3:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    // Fixed-priority selector model, optionally overridden to inject malformed grants.
    always_comb begin
        if (frc)         gnt_in = fgnt;
        else if (en_out) gnt_in = bit_of(hi_idx(req_masked));
        else             gnt_in = '0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {gnt_out, en_out, busy, timeout, req_masked};
    endfunction

    // Ownership model: who holds the bus, for how many cycles so far, whether a dead cycle is due.
    int m_owner;
    int m_held;
    int m_pen;
    bit m_gap;
    bit m_to;

    task automatic m_reset();
        m_owner = -1; m_held = 0; m_pen = -1; m_gap = 1'b0; m_to = 1'b0;
    endtask

    function automatic logic [10:0] m_expect(input logic [3:0] r);
        logic [3:0] g;
        logic e, b;
        g = bit_of(m_owner);
        e = (m_owner < 0) && !m_gap;
        b = (m_owner >= 0);
        return {g, e, b, m_to, r & ~bit_of(m_pen)};
    endfunction

    task automatic m_step(input logic [3:0] r, input logic [3:0] g);
        bit to_n;
        int hi;
        to_n = 1'b0;
        hi = hi_idx(g);
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1; m_gap = 1'b1;
            end else if (m_held == int'(MAX_HOLD)) begin
                m_pen = m_owner; to_n = 1'b1; m_owner = -1; m_gap = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (hi >= 0) begin
            m_owner = hi; m_held = 1; m_pen = -1;
        end else if ((r & ~bit_of(m_pen)) == 4'b0000) begin
            m_pen = -1;
        end
        m_to = to_n;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       frc;
        logic [3:0] fgnt;
        logic [3:0] gnt;
        logic       en;
        logic       busy;
        logic       to;
        logic [3:0] rm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic [3:0] r, input logic f, input logic [3:0] fg,
                       input logic [3:0] g, input logic e, input logic b, input logic t,
                       input logic [3:0] rm);
        vec_t v;
        v = '{r, f, fg, g, e, b, t, rm};
        repeat (n) vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] rs, gs, rr;
        logic [3:0] prev_gnt;
        bit         chg;

        // release after 2 cycles
        add(1, 4'b0010, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b0010);
        add(1, 4'b0010, 0, 4'b0, 4'b0010, 0, 1, 0, 4'b0010);
        add(1, 4'b0000, 0, 4'b0, 4'b0010, 0, 1, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0, 4'b0000, 0, 0, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b0000);
        // hogging high-priority client times out, lower one gets through
        add(1, 4'b1001, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b1001);
        add(4, 4'b1001, 0, 4'b0, 4'b1000, 0, 1, 0, 4'b1001);
        add(1, 4'b1001, 0, 4'b0, 4'b0000, 0, 0, 1, 4'b0001);
        add(1, 4'b1001, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b0001);
        add(1, 4'b1001, 0, 4'b0, 4'b0001, 0, 1, 0, 4'b1001);
        add(1, 4'b0000, 0, 4'b0, 4'b0001, 0, 1, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0, 4'b0000, 0, 0, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b0000);
        // lone hogger: penalty cleared by an empty arbitration, then regranted
        add(1, 4'b1000, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b1000);
        add(4, 4'b1000, 0, 4'b0, 4'b1000, 0, 1, 0, 4'b1000);
        add(1, 4'b1000, 0, 4'b0, 4'b0000, 0, 0, 1, 4'b0000);
        add(1, 4'b1000, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b0000);
        add(1, 4'b1000, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b1000);
        add(1, 4'b1000, 0, 4'b0, 4'b1000, 0, 1, 0, 4'b1000);
        add(1, 4'b0000, 0, 4'b0, 4'b1000, 0, 1, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0, 4'b0000, 0, 0, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b0000);
        // release exactly at the last count: no timeout, no penalty
        add(1, 4'b0100, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b0100);
        add(3, 4'b0100, 0, 4'b0, 4'b0100, 0, 1, 0, 4'b0100);
        add(1, 4'b0000, 0, 4'b0, 4'b0100, 0, 1, 0, 4'b0000);
        add(1, 4'b0100, 0, 4'b0, 4'b0000, 0, 0, 0, 4'b0100);
        add(1, 4'b0100, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b0100);
        add(1, 4'b0000, 0, 4'b0, 4'b0100, 0, 1, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0, 4'b0000, 0, 0, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0, 4'b0000, 1, 0, 0, 4'b0000);
        // malformed two-bit grant
        add(1, 4'b0110, 1, 4'b0110, 4'b0000, 1, 0, 0, 4'b0110);
        add(1, 4'b0000, 0, 4'b0,    4'b0100, 0, 1, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0,    4'b0000, 0, 0, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0,    4'b0000, 1, 0, 0, 4'b0000);

        reset = 1'b1; req = '0; frc = 1'b0; fgnt = '0;
        #12;
        check("reset_state", 32'(outs()), 32'(11'b0000_1_0_0_0000));
        reset = 1'b0;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            req = vecs[i].req; frc = vecs[i].frc; fgnt = vecs[i].fgnt;
            #3;
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({vecs[i].gnt, vecs[i].en, vecs[i].busy, vecs[i].to, vecs[i].rm}));
            @(posedge clock); #1;
        end
        frc = 1'b0;

        // asynchronous reset while owning
        req = 4'b0100;
        @(posedge clock); #1;
        check("t1_own", 32'(gnt_out), 32'(4'b0100));
        #2; reset = 1'b1; #1;
        check("t1_async", 32'({gnt_out, en_out, busy}), 32'(6'b0000_1_0));
        #2; reset = 1'b0; #1;
        check("t1_pen", 32'(req_masked), 32'(4'b0100));
        req = '0;
        @(posedge clock); #1;

        // randomised soak against the ownership model
        reset = 1'b1; #2; reset = 1'b0;
        m_reset();
        @(posedge clock); #1;
        rr = '0;
        prev_gnt = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
            req  = rr;
            frc  = ($urandom_range(0, 15) == 0);
            fgnt = 4'($urandom);
            #3;
            check("soak_outs", 32'(outs()), 32'(m_expect(req)));
            check("soak_onehot", 32'($onehot0(gnt_out)), 32'd1);
            chg = (prev_gnt != 4'b0000) && (gnt_out != 4'b0000) && (gnt_out != prev_gnt);
            check("soak_gap", 32'(chg), 32'd0);
            prev_gnt = gnt_out;
            rs = req; gs = gnt_in;
            @(posedge clock); #1;
            m_step(rs, gs);
        end
        frc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grant_lock.md
Name: grant_lock

Overview:
- Sequential ownership stage wrapped around the 4-way fixed-priority selector.
- Upstream role: masks raw client requests and drives the selector's req and en inputs.
- Downstream role: consumes the selector's one-hot grant and latches it into a registered bus owner. The owner holds the grant until it drops its request or a hold limit expires.
- Timeout penalty: a timed-out owner is masked for one arbitration, so a hogging high-priority client cannot starve lower ones.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one owner may hold gnt_out (legal range 2..255).
- CW, $clog2(MAX_HOLD), hold counter width (derived; do not override).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  raw client requests; bit 3 is highest priority.
- gnt_in  input  4  one-hot grant returned combinationally by the priority selector.
- req_masked  output  4  req & ~penalty; drives the selector's req.
- en_out  output  1  drives the selector's en; high only in IDLE.
- gnt_out  output  4  registered one-hot owner grant to clients.
- busy  output  1  high while in OWN.
- timeout  output  1  registered, one-cycle pulse when an owner is forcibly released.

Behaviour:
- Reset (async, active-high): state=IDLE, owner=0, gnt_out=0, count=0, penalty=0, timeout=0. Outputs are valid during reset (en_out=1, busy=0). Reset mid-OWN drops gnt_out immediately.
- State IDLE:
  - en_out=1, gnt_out=0.
  - If gnt_in!=0: latch owner=gnt_in, count=0, clear penalty, go OWN.
  - If gnt_in==0 and req_masked==0 and penalty!=0: clear penalty, stay IDLE. A penalised lone requester is granted on the following arbitration.
  - Otherwise stay IDLE.
- State OWN:
  - en_out=0, gnt_out=owner, busy=1.
  - Release: if (req & owner)==0, go GAP with no penalty.
  - Timeout: else if count==MAX_HOLD-1, set penalty|=owner, pulse timeout next cycle, go GAP.
  - Otherwise count++ and stay OWN.
- State GAP:
  - One dead cycle: gnt_out=0, en_out=0, busy=0.
  - Unconditionally go IDLE. This guarantees a break-before-make gap between owners.
- Latency:
  - Request arrives with block in IDLE: gnt_out asserts on the next rising edge (1 cycle).
  - From release to next grant: GAP + IDLE = gnt_out low for exactly 2 cycles.
- Max hold: an owner that keeps req high sees gnt_out high for exactly MAX_HOLD cycles.
- Owner's req drop in the same cycle count reaches MAX_HOLD-1: treated as a release (no penalty, no timeout pulse).
- gnt_in with more than one bit set (protocol violation): latch only its highest set bit. gnt_out must never have more than one bit set.
- Requests changing during OWN or GAP: ignored until IDLE, except the owner's own bit.
- penalty holds at most one set bit. It is cleared on any new grant latch or by the lone-requester rule.
- count saturates at MAX_HOLD-1 (cannot wrap) and resets to 0 on every new grant.

Test Plan (MAX_HOLD=4):
1. reset high mid-OWN with gnt_out=0100 -> gnt_out=0000, en_out=1, busy=0 immediately, without waiting for a clock edge; penalty=0 after release.
2. req=0010 held 2 cycles, then 0000 -> gnt_out=0010 for 2 cycles, GAP, IDLE; timeout never pulses.
3. req=1001 held constant -> gnt_out=1000 for 4 cycles; timeout pulse; 2 low cycles (req_masked=0001); gnt_out=0001; penalty cleared on that grant.
4. req=1000 alone held constant -> 4 cycles of 1000; timeout; GAP; IDLE with req_masked=0, penalty cleared; 1000 regranted 1 cycle later.
5. req=0100, owner releases at count=3 -> GAP, no timeout pulse, penalty stays 0000.
6. Force gnt_in=0110 in IDLE -> gnt_out=0100 only; randomised soak checks $onehot0(gnt_out) every cycle and a ≥1-cycle zero gap between different owners.
